// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int KEY_W    = 8;

  typedef enum logic [1:0] {
    SCAN      = 2'd0,
    DEB_PRESS = 2'd1,
    HELD      = 2'd2,
    DEB_REL   = 2'd3
  } scan_state_t;

  function automatic logic onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// Parameterised-width two-flop synchronizer; resets to all ones (idle pulled-up rows).
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with press/release debounce and first-key lock.
// Optional auto-repeat while held: define KEYPAD_AUTOREPEAT_EN.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int REPEAT_CYCLES   = 500000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_ROWS-1:0] row_n,
  output logic [NUM_COLS-1:0] col_n,
  output logic [KEY_W-1:0]    key_val,
  output logic                key_valid,
  output logic                key_held
);

  localparam int SLOT_W = $clog2(SCAN_DIV);
  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);

  // The sync latency of two cycles must settle inside one column slot.
  generate
    if (SCAN_DIV < 4 || DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
      $error("keypad_scanner: SCAN_DIV must be >= 4, DEBOUNCE/REPEAT >= 2");
    end
  endgenerate

  logic [NUM_ROWS-1:0] w_row_sync;
  logic [NUM_ROWS-1:0] w_rows_s;
  logic                w_cand_hit;

  scan_state_t         r_state;
  logic [NUM_COLS-1:0] r_col_n;
  logic [SLOT_W-1:0]   r_slot;
  logic [DEB_W-1:0]    r_deb;
  logic [KEY_W-1:0]    r_cand;
  logic [KEY_W-1:0]    r_key_val;
  logic                r_key_valid;
  logic                r_key_held;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
  logic [REP_W-1:0] r_rep;
`endif

  sync_2ff #(.WIDTH(NUM_ROWS)) u_row_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (row_n),
    .o_q   (w_row_sync)
  );

  assign w_rows_s   = ~w_row_sync;
  assign w_cand_hit = |(w_rows_s & r_cand[KEY_W-1:NUM_COLS]);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= SCAN;
      r_col_n     <= 4'b1110;
      r_slot      <= '0;
      r_deb       <= '0;
      r_cand      <= '0;
      r_key_val   <= '0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      r_rep       <= '0;
`endif
    end else begin
      r_key_valid <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      r_rep       <= '0;
`endif
      case (r_state)
        SCAN: begin
          if (r_slot == SLOT_LAST) begin
            r_slot <= '0;
            if (onehot4(w_rows_s)) begin
              r_cand  <= {w_rows_s, ~r_col_n};
              r_deb   <= '0;
              r_state <= DEB_PRESS;
            end else begin
              r_col_n <= {r_col_n[2:0], r_col_n[3]};
            end
          end else begin
            r_slot <= r_slot + SLOT_W'(1);
          end
        end
        DEB_PRESS: begin
          if (w_rows_s == r_cand[KEY_W-1:NUM_COLS]) begin
            if (r_deb == DEB_LAST) begin
              r_key_val   <= r_cand;
              r_key_valid <= 1'b1;
              r_key_held  <= 1'b1;
              r_state     <= HELD;
            end else begin
              r_deb <= r_deb + DEB_W'(1);
            end
          end else begin
            r_col_n <= {r_col_n[2:0], r_col_n[3]};
            r_state <= SCAN;
          end
        end
        HELD: begin
          if (!w_cand_hit) begin
            r_deb   <= '0;
            r_state <= DEB_REL;
          end
`ifdef KEYPAD_AUTOREPEAT_EN
          else if (r_rep == REP_LAST) begin
            r_key_valid <= 1'b1;
          end else begin
            r_rep <= r_rep + REP_W'(1);
          end
`endif
        end
        DEB_REL: begin
          if (w_cand_hit) begin
            r_state <= HELD;
          end else if (r_deb == DEB_LAST) begin
            r_col_n    <= {r_col_n[2:0], r_col_n[3]};
            r_key_held <= 1'b0;
            r_state    <= SCAN;
          end else begin
            r_deb <= r_deb + DEB_W'(1);
          end
        end
        default: r_state <= SCAN;
      endcase
    end
  end

  assign col_n     = r_col_n;
  assign key_val   = r_key_val;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench: a behavioural 4x4 key matrix drives row_n from col_n and pressed keys.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 8;
  localparam int REP      = 16;
  localparam int PRESS_BOUND = 5 * SCAN_DIV + DEB + 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [7:0] key_val;
  logic       key_valid;
  logic       key_held;

  logic [15:0] keys;   // bit r*4+c: key at row r, column c is pressed
  int vectors   = 0;
  int errors    = 0;
  int n_strobes = 0;

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_DIV        (SCAN_DIV),
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_CYCLES   (REP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_val   (key_val),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  // A row reads low when any pressed key on it sits in a column driven low.
  always_comb begin
    row_n = '1;
    for (int unsigned r = 0; r < 4; r++)
      row_n[r] = ~|(keys[r*4 +: 4] & ~col_n);
  end

  always @(posedge clk) if (key_valid) n_strobes++;

  function automatic logic [7:0] exp_code(input int r, input int c);
    logic [3:0] rr, cc;
    rr = 4'(1 << r);
    cc = 4'(1 << c);
    return {rr, cc};
  endfunction

  task automatic wait_strobe(input int bound, output int cyc, output bit ok);
    ok = 1'b0; cyc = 0;
    for (int i = 1; i <= bound; i++) begin
      @(negedge clk);
      if (key_valid) begin cyc = i; ok = 1'b1; break; end
    end
  endtask

  task automatic wait_col(input logic [3:0] target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 16 * SCAN_DIV; i++) begin
      @(negedge clk);
      if (col_n == target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    logic [3:0] e;
    reset = 1'b1; keys = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if (col_n !== 4'b1110) begin errors++; $display("FAIL reset_col_n: got %b expected 1110", col_n); end
    vectors++; if (key_val !== 8'h00) begin errors++; $display("FAIL reset_key_val: got %h expected 00", key_val); end
    vectors++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_key_valid: got %b expected 0", key_valid); end
    vectors++; if (key_held !== 1'b0) begin errors++; $display("FAIL reset_key_held: got %b expected 0", key_held); end
    reset = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); @(negedge clk);
      e = ~(4'b0001 << ((k / SCAN_DIV) % 4));
      vectors++; if (col_n !== e) begin errors++; $display("FAIL rotate_col_n cycle %0d: got %b expected %b", k, col_n, e); end
    end
  endtask

  task automatic test_single_key();
    int base, n; bit ok, found;
    base = n_strobes;
    wait_col(4'b1110, ok);
    keys = '0; keys[1*4+3] = 1'b1;
    wait_col(4'b0111, ok);
    vectors++; if (!ok) begin errors++; $display("FAIL single_col3_timeout: column 3 never driven"); end
    found = 1'b0; n = 0;
    for (int i = 1; i <= PRESS_BOUND; i++) begin
      @(negedge clk);
      if (key_valid) begin n = i; found = 1'b1; break; end
    end
    vectors++; if (!found) begin errors++; $display("FAIL single_strobe_timeout: no key_valid within %0d cycles", PRESS_BOUND); end
    vectors++; if (n != SCAN_DIV + DEB) begin errors++; $display("FAIL single_latency: got %0d expected %0d", n, SCAN_DIV + DEB); end
    vectors++; if (key_val !== 8'b0010_1000) begin errors++; $display("FAIL single_key_val: got %b expected 00101000", key_val); end
    vectors++; if (key_held !== 1'b1) begin errors++; $display("FAIL single_held: got %b expected 1", key_held); end
    repeat (6) @(negedge clk);
    vectors++; if (n_strobes - base != 1) begin errors++; $display("FAIL single_strobe_count: got %0d expected 1", n_strobes - base); end
    keys = '0;
    repeat (2 + DEB) @(posedge clk);
    @(negedge clk);
    vectors++; if (key_held !== 1'b1) begin errors++; $display("FAIL release_held_during_debounce: got %b expected 1", key_held); end
    @(posedge clk); @(negedge clk);
    vectors++; if (key_held !== 1'b0) begin errors++; $display("FAIL release_held_after: got %b expected 0", key_held); end
    vectors++; if (col_n !== 4'b1110) begin errors++; $display("FAIL release_col_advance: got %b expected 1110", col_n); end
    vectors++; if (key_val !== 8'b0010_1000) begin errors++; $display("FAIL release_key_val_kept: got %b expected 00101000", key_val); end
    repeat (SCAN_DIV) @(posedge clk);
    @(negedge clk);
    vectors++; if (col_n !== 4'b1101) begin errors++; $display("FAIL release_scan_resumes: got %b expected 1101", col_n); end
  endtask

  task automatic test_bounce();
    int base, c, cyc; bit ok;
    base = n_strobes;
    c = $urandom_range(0, 3);
    wait_col(~(4'b0001 << c), ok);
    for (int p = 0; p < 16; p++) begin
      keys = '0; keys[c] = (p % 2 == 0);
      repeat (3) @(negedge clk);
    end
    keys = '0;
    repeat (DEB + 4) @(negedge clk);
    vectors++; if (n_strobes != base) begin errors++; $display("FAIL bounce_no_strobe: got %0d strobes expected 0", n_strobes - base); end
    vectors++; if (key_held !== 1'b0) begin errors++; $display("FAIL bounce_not_held: got %b expected 0", key_held); end
    keys[c] = 1'b1;
    wait_strobe(PRESS_BOUND, cyc, ok);
    vectors++; if (!ok) begin errors++; $display("FAIL bounce_stable_timeout: no key_valid within %0d cycles", PRESS_BOUND); end
    vectors++; if (key_val !== exp_code(0, c)) begin errors++; $display("FAIL bounce_key_val: got %b expected %b", key_val, exp_code(0, c)); end
    repeat (4) @(negedge clk);
    vectors++; if (n_strobes - base != 1) begin errors++; $display("FAIL bounce_strobe_count: got %0d expected 1", n_strobes - base); end
    keys = '0;
    repeat (3 + DEB + 2) @(negedge clk);
    vectors++; if (key_held !== 1'b0) begin errors++; $display("FAIL bounce_release: held %b expected 0", key_held); end
  endtask

  task automatic test_release_glitch();
    int base, r, c, cyc, glen; bit ok;
    base = n_strobes;
    r = $urandom_range(0, 3); c = $urandom_range(0, 3);
    keys = '0; keys[r*4+c] = 1'b1;
    wait_strobe(PRESS_BOUND, cyc, ok);
    vectors++; if (!ok) begin errors++; $display("FAIL glitch_press_timeout: no key_valid within %0d cycles", PRESS_BOUND); end
    vectors++; if (key_val !== exp_code(r, c)) begin errors++; $display("FAIL glitch_key_val: got %b expected %b", key_val, exp_code(r, c)); end
    for (int g = 0; g < 2; g++) begin
      glen = (g == 0) ? 5 : DEB - 1;
      repeat (2) @(negedge clk);
      keys[r*4+c] = 1'b0;
      repeat (glen) @(negedge clk);
      keys[r*4+c] = 1'b1;
      repeat (10) @(negedge clk);
      vectors++; if (key_held !== 1'b1) begin errors++; $display("FAIL glitch_%0d_held: got %b expected 1", glen, key_held); end
      vectors++; if (n_strobes - base != 1) begin errors++; $display("FAIL glitch_%0d_strobes: got %0d expected 1", glen, n_strobes - base); end
    end
    keys = '0;
    repeat (3 + DEB + 2) @(negedge clk);
    vectors++; if (key_held !== 1'b0) begin errors++; $display("FAIL glitch_release: held %b expected 0", key_held); end
  endtask

  task automatic test_ghost_and_lock();
    int base, c, ra, ca, rb, cb, cyc; bit ok;
    base = n_strobes;
    c = $urandom_range(0, 3);
    keys = '0; keys[0*4+c] = 1'b1; keys[2*4+c] = 1'b1;
    repeat (12 * SCAN_DIV) @(negedge clk);
    vectors++; if (n_strobes != base) begin errors++; $display("FAIL ghost_strobe: got %0d strobes expected 0", n_strobes - base); end
    vectors++; if (key_held !== 1'b0) begin errors++; $display("FAIL ghost_held: got %b expected 0", key_held); end
    keys = '0;
    repeat (4) @(negedge clk);
    ra = $urandom_range(0, 3); ca = $urandom_range(0, 3);
    rb = $urandom_range(0, 3); cb = (ca + 1 + $urandom_range(0, 2)) % 4;
    keys[ra*4+ca] = 1'b1;
    wait_strobe(PRESS_BOUND, cyc, ok);
    vectors++; if (!ok) begin errors++; $display("FAIL lock_a_timeout: no key_valid within %0d cycles", PRESS_BOUND); end
    vectors++; if (key_val !== exp_code(ra, ca)) begin errors++; $display("FAIL lock_a_key_val: got %b expected %b", key_val, exp_code(ra, ca)); end
    keys[rb*4+cb] = 1'b1;
    repeat (6) @(negedge clk);
    vectors++; if (n_strobes - base != 1) begin errors++; $display("FAIL lock_b_ignored: got %0d strobes expected 1", n_strobes - base); end
    keys[ra*4+ca] = 1'b0;
    wait_strobe(3 + DEB + PRESS_BOUND, cyc, ok);
    vectors++; if (!ok) begin errors++; $display("FAIL lock_b_timeout: B not accepted after A released"); end
    vectors++; if (key_val !== exp_code(rb, cb)) begin errors++; $display("FAIL lock_b_key_val: got %b expected %b", key_val, exp_code(rb, cb)); end
    repeat (2) @(negedge clk);
    vectors++; if (n_strobes - base != 2) begin errors++; $display("FAIL lock_b_strobes: got %0d expected 2", n_strobes - base); end
    keys = '0;
    repeat (3 + DEB + 2) @(negedge clk);
    vectors++; if (key_held !== 1'b0) begin errors++; $display("FAIL lock_b_release: held %b expected 0", key_held); end
  endtask

  task automatic test_random_keys();
    int base, r, c, cyc; bit ok;
    for (int it = 0; it < 6; it++) begin
      base = n_strobes;
      r = $urandom_range(0, 3); c = $urandom_range(0, 3);
      repeat ($urandom_range(0, 7)) @(negedge clk);
      keys = '0; keys[r*4+c] = 1'b1;
      wait_strobe(PRESS_BOUND, cyc, ok);
      vectors++; if (!ok) begin errors++; $display("FAIL rand_%0d_timeout: no key_valid for r%0d c%0d", it, r, c); end
      vectors++; if (key_val !== exp_code(r, c)) begin errors++; $display("FAIL rand_%0d_key_val: got %b expected %b", it, key_val, exp_code(r, c)); end
      vectors++; if (key_held !== 1'b1) begin errors++; $display("FAIL rand_%0d_held: got %b expected 1", it, key_held); end
      repeat ($urandom_range(1, 8)) @(negedge clk);
      keys = '0;
      repeat (3 + DEB + 2) @(negedge clk);
      vectors++; if (key_held !== 1'b0) begin errors++; $display("FAIL rand_%0d_release: held %b expected 0", it, key_held); end
      vectors++; if (n_strobes - base != 1) begin errors++; $display("FAIL rand_%0d_strobes: got %0d expected 1", it, n_strobes - base); end
      vectors++; if (key_val !== exp_code(r, c)) begin errors++; $display("FAIL rand_%0d_val_kept: got %b expected %b", it, key_val, exp_code(r, c)); end
    end
  endtask

  task automatic test_repeat_and_reset();
    int base, cyc; bit ok;
    base = n_strobes;
    keys = '0; keys[2*4+2] = 1'b1;
    wait_strobe(PRESS_BOUND, cyc, ok);
    vectors++; if (!ok) begin errors++; $display("FAIL hold_press_timeout: no key_valid within %0d cycles", PRESS_BOUND); end
    vectors++; if (key_val !== 8'b0100_0100) begin errors++; $display("FAIL hold_key_val: got %b expected 01000100", key_val); end
`ifdef KEYPAD_AUTOREPEAT_EN
    for (int i = 0; i < 3; i++) begin
      wait_strobe(REP + 2, cyc, ok);
      vectors++; if (!ok || cyc != REP) begin errors++; $display("FAIL repeat_%0d_period: got %0d expected %0d", i, cyc, REP); end
      vectors++; if (key_val !== 8'b0100_0100) begin errors++; $display("FAIL repeat_%0d_key_val: got %b expected 01000100", i, key_val); end
    end
`else
    repeat (4 * REP) @(negedge clk);
    vectors++; if (n_strobes - base != 1) begin errors++; $display("FAIL hold_single_strobe: got %0d expected 1", n_strobes - base); end
`endif
    repeat ($urandom_range(1, 5)) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    vectors++; if (col_n !== 4'b1110) begin errors++; $display("FAIL midreset_col_n: got %b expected 1110", col_n); end
    vectors++; if (key_val !== 8'h00) begin errors++; $display("FAIL midreset_key_val: got %h expected 00", key_val); end
    vectors++; if (key_valid !== 1'b0) begin errors++; $display("FAIL midreset_key_valid: got %b expected 0", key_valid); end
    vectors++; if (key_held !== 1'b0) begin errors++; $display("FAIL midreset_key_held: got %b expected 0", key_held); end
    reset = 1'b0; keys = '0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    keys  = '0;
    test_reset();
    test_single_key();
    test_bounce();
    test_release_glitch();
    test_ghost_and_lock();
    test_random_keys();
    test_repeat_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 matrix keypad by driving columns low one at a time and sampling the active-low rows.
- Debounces key press and key release; locks onto the first key pressed and ignores other keys while it is held.
- Emits a one-hot 8-bit code {row[3:0], col[3:0]} with a one-cycle valid strobe.
- Sits directly upstream of the keypad-to-hex decoder; key_val connects straight to the decoder's 8-bit input.

Parameters:
- SCAN_DIV, 1000, clock cycles per column slot; must be at least 4.
- DEBOUNCE_CYCLES, 20000, stable cycles required to accept a press or a release.
- REPEAT_CYCLES, 500000, auto-repeat period; used only when the optional feature is compiled in.

Ports:
- clk  input  1  system clock (one clock domain).
- reset  input  1  synchronous, active-high reset.
- row_n  input  4  raw keypad rows, active-low, asynchronous to clk, externally pulled up.
- col_n  output  4  column drive, active-low, exactly one bit low at all times.
- key_val  output  8  {row one-hot, col one-hot} of the last accepted key; row_n[i] maps to bit 4+i, col_n[j] maps to bit j.
- key_valid  output  1  one-cycle strobe on each accepted key.
- key_held  output  1  high while an accepted key is held (HELD state).

Behaviour:
- Reset (synchronous, active-high) forces:
  - col_n=4'b1110 and column index 0; slot counter, debounce counter and repeat counter =0.
  - key_val=8'h00, key_valid=0, key_held=0, state=SCAN, synchronizer flops=4'b1111.
- Synchronizer: row_n passes through a 2-flop synchronizer. rows_s = ~synced row_n, active-high. Latency 2 cycles.
- SCAN:
  - Slot counter counts 0..SCAN_DIV-1. At SCAN_DIV-1 it evaluates rows_s.
  - Exactly one bit of rows_s set: capture cand = {rows_s, ~col_n}, clear the debounce counter, go to DEB_PRESS. The column does not advance.
  - Zero or two-plus bits set (ghosting): the column index advances (3 wraps to 0) and the slot counter clears.
- DEB_PRESS:
  - Column is frozen.
  - Each cycle rows_s==cand[7:4], the counter increments. Any mismatch returns to SCAN with the column advanced.
  - When the counter reaches DEBOUNCE_CYCLES-1 and still matches: key_val<=cand, key_valid=1 for the next cycle only, go to HELD.
- HELD:
  - Column is frozen; key_held=1.
  - Other keys are ignored: extra row bits are don't-care.
  - When the cand row bit deasserts, clear the counter and go to DEB_REL.
- DEB_REL:
  - Counts while the cand row bit is deasserted.
  - If it reasserts before DEBOUNCE_CYCLES, return to HELD with no new key_valid.
  - When the count completes, go to SCAN with the column advanced and key_held=0.
- Press acceptance latency: measured from the first synced sample, DEBOUNCE_CYCLES+1 cycles to key_valid.
- key_val holds its last accepted value until the next acceptance; it does not clear on release.
- Reset asserted in any state returns to the reset values on the next edge; no strobe is emitted.
- Counters are sized with $clog2 of their parameter, and comparisons are done at that width.

Optional Feature:
- KEYPAD_AUTOREPEAT_EN defined:
  - In HELD, a repeat counter counts up; at REPEAT_CYCLES-1, key_valid pulses one cycle (key_val unchanged) and the counter clears.
  - The counter clears on entry to HELD and in every other state.
- Undefined: no repeat logic is present; exactly one key_valid per press.

Decomposition:
- Package keypad_pkg:
  - typedef enum logic [1:0] scan_state_t {SCAN, DEB_PRESS, HELD, DEB_REL}.
  - Constants NUM_ROWS=4, NUM_COLS=4, KEY_W=8.
- One sub-module, sync_2ff: parameterised-width 2-flop synchronizer, reset to all ones. Used for row_n.

Test Plan:
1. Reset with SCAN_DIV=4, DEBOUNCE_CYCLES=8 → col_n=1110, key_val=00, key_valid=0; col_n rotates 1101, 1011, 0111, 1110 every 4 cycles.
2. Hold row_n[1] low while col_n[3] is low → exactly one key_valid, key_val=8'b0010_1000, key_held=1; release and wait 8+ cycles → key_held=0, scanning resumes.
3. Bounce: toggle row_n[0] every 3 cycles during DEB_PRESS → no key_valid, returns to SCAN; a stable press afterwards → one strobe.
4. Release glitch: during HELD, deassert the row for 5 cycles (<8) then reassert → stays HELD, no second strobe.
5. Two rows low in the same column → ghost rejected, no strobe. Key A held, then key B in another column pressed → no strobe for B; after A is released and debounced, with B still held, B is accepted.
6. With KEYPAD_AUTOREPEAT_EN and REPEAT_CYCLES=16, hold key 8'b0100_0100 → initial strobe, then a strobe every 16 cycles with key_val unchanged. Assert reset mid-hold → all outputs return to reset values the next cycle.
